// File: rtl/inst_mem_loader_if.sv
// Loader bus bundle: load control, byte-stream handshake, word write port and status.
// The slave modport is the loader's view; master is the host/bench side.
interface inst_mem_loader_if #(
  parameter int ADDR_W = 32
);
  logic              start;
  logic [15:0]       load_len;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              write_enable;
  logic [ADDR_W-1:0] wr_address;
  logic [31:0]       wr_data;
  logic              busy;
  logic              done;
  logic              error;
  logic              cpu_hold;

  modport slave (
    input  start, load_len, byte_valid, byte_data,
    output byte_ready, write_enable, wr_address, wr_data, busy, done, error, cpu_hold
  );

  modport master (
    output start, load_len, byte_valid, byte_data,
    input  byte_ready, write_enable, wr_address, wr_data, busy, done, error, cpu_hold
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Packs a byte stream into little-endian 32-bit words and writes them to the
// instruction ROM at ascending addresses, holding the CPU until the image is in.
module inst_mem_loader #(
  parameter int          ADDR_W          = 32,
  parameter int          MEM_DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR       = 32'h0
) (
  input  logic clk,
  input  logic rst_n,
  inst_mem_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DONE, ERR} state_t;

  localparam logic [16:0] DEPTH = 17'(MEM_DEPTH_WORDS);

  state_t            state;
  logic [1:0]        byte_idx;
  logic [15:0]       word_idx;
  logic [15:0]       len_q;
  logic [23:0]       asm_q;     // bytes 0..2; byte 3 goes straight into wr_data
  logic [ADDR_W-1:0] word_addr;
  logic              too_big;

  assign word_addr = ADDR_W'(BASE_ADDR) + ADDR_W'({word_idx, 2'b00});
  assign too_big   = {1'b0, bus.load_len} > DEPTH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      byte_idx         <= '0;
      word_idx         <= '0;
      len_q            <= '0;
      asm_q            <= '0;
      bus.byte_ready   <= 1'b0;
      bus.write_enable <= 1'b0;
      bus.wr_address   <= '0;
      bus.wr_data      <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.error        <= 1'b0;
      bus.cpu_hold     <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (bus.start) begin
            bus.done  <= 1'b0;
            bus.error <= 1'b0;
            if (bus.load_len == 16'd0) begin
              state        <= DONE;
              bus.done     <= 1'b1;
              bus.cpu_hold <= 1'b0;
            end else if (too_big) begin
              state        <= ERR;
              bus.error    <= 1'b1;
              bus.cpu_hold <= 1'b1;
            end else begin
              state          <= COLLECT;
              len_q          <= bus.load_len;
              word_idx       <= '0;
              byte_idx       <= '0;
              bus.busy       <= 1'b1;
              bus.byte_ready <= 1'b1;
              bus.cpu_hold   <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (bus.byte_valid && bus.byte_ready) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: asm_q[7:0]   <= bus.byte_data;
              2'd1: asm_q[15:8]  <= bus.byte_data;
              2'd2: asm_q[23:16] <= bus.byte_data;
              default: begin
                state            <= WRITE;
                bus.byte_ready   <= 1'b0;
                bus.write_enable <= 1'b1;
                bus.wr_data      <= {bus.byte_data, asm_q};
                bus.wr_address   <= word_addr;
              end
            endcase
          end
        end
        WRITE: begin
          bus.write_enable <= 1'b0;
          word_idx         <= word_idx + 16'd1;
          byte_idx         <= '0;
          if (word_idx + 16'd1 == len_q) begin
            state        <= DONE;
            bus.done     <= 1'b1;
            bus.busy     <= 1'b0;
            bus.cpu_hold <= 1'b0;
          end else begin
            state          <= COLLECT;
            bus.byte_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: expected writes go into a queue as stimulus
// is issued; a negedge monitor pops and compares on every write strobe.
module tb_inst_mem_loader;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  wr_t  exp_q[$];

  inst_mem_loader_if #(.ADDR_W(32)) bif ();

  inst_mem_loader #(.ADDR_W(32), .MEM_DEPTH_WORDS(256), .BASE_ADDR(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Monitor: scoreboard on writes, plus handshake/hold invariants every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bif.write_enable) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write addr=%h data=%h", bif.wr_address, bif.wr_data);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          chk("wr_address", bif.wr_address, w.addr);
          chk("wr_data", bif.wr_data, w.data);
        end
      end
      if (bif.busy) chk("ready_only_low_in_write", 32'(bif.byte_ready), 32'(!bif.write_enable));
      chk("cpu_hold_vs_done", 32'(bif.cpu_hold), 32'(!bif.done));
    end
  end

  task automatic check_reset_vals();
    chk("rst_byte_ready", 32'(bif.byte_ready), 0);
    chk("rst_write_enable", 32'(bif.write_enable), 0);
    chk("rst_wr_address", bif.wr_address, 0);
    chk("rst_wr_data", bif.wr_data, 0);
    chk("rst_busy", 32'(bif.busy), 0);
    chk("rst_done", 32'(bif.done), 0);
    chk("rst_error", 32'(bif.error), 0);
    chk("rst_cpu_hold", 32'(bif.cpu_hold), 1);
  endtask

  task automatic do_start(input logic [15:0] len);
    bif.start    = 1'b1;
    bif.load_len = len;
    @(posedge clk); #1;
    bif.start    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    if (gap) begin
      bif.byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    bif.byte_valid = 1'b1;
    bif.byte_data  = b;
    while (!bif.byte_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL byte_timeout got=ready_low want=ready_high");
    end
    @(posedge clk); #1;
    bif.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(bif.done || bif.error) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL end_timeout got=busy want=done_or_error");
    end
  endtask

  initial begin
    bif.start      = 1'b0;
    bif.load_len   = '0;
    bif.byte_valid = 1'b0;
    bif.byte_data  = '0;
    #12;
    check_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two-word load, back-to-back bytes
    expect_wr(32'h0, 32'h0000_0013);
    expect_wr(32'h4, 32'h0010_0093);
    do_start(16'd2);
    chk("t1_busy", 32'(bif.busy), 1);
    send_word(32'h0000_0013, 1'b0);
    send_word(32'h0010_0093, 1'b0);
    wait_end();
    chk("t1_done", 32'(bif.done), 1);
    chk("t1_cpu_hold", 32'(bif.cpu_hold), 0);
    chk("t1_q_empty", 32'(exp_q.size()), 0);

    // Same load, byte_valid toggling
    expect_wr(32'h0, 32'h0000_0013);
    expect_wr(32'h4, 32'h0010_0093);
    do_start(16'd2);
    chk("t2_done_cleared", 32'(bif.done), 0);
    send_word(32'h0000_0013, 1'b1);
    send_word(32'h0010_0093, 1'b1);
    wait_end();
    repeat (3) @(posedge clk);
    #1;
    chk("t2_done", 32'(bif.done), 1);
    chk("t2_q_empty", 32'(exp_q.size()), 0);

    // Oversized load rejected, then a normal 1-word load clears the error
    do_start(16'd257);
    chk("t3_error", 32'(bif.error), 1);
    chk("t3_done", 32'(bif.done), 0);
    chk("t3_cpu_hold", 32'(bif.cpu_hold), 1);
    chk("t3_busy", 32'(bif.busy), 0);
    expect_wr(32'h0, 32'hDEAD_BEEF);
    do_start(16'd1);
    chk("t3_error_cleared", 32'(bif.error), 0);
    send_word(32'hDEAD_BEEF, 1'b0);
    wait_end();
    chk("t3_done_after", 32'(bif.done), 1);
    chk("t3_q_empty", 32'(exp_q.size()), 0);

    // Exact capacity is accepted; zero-length completes with no write
    do_start(16'd257);
    chk("t4_error", 32'(bif.error), 1);
    do_start(16'd0);
    chk("t4_done", 32'(bif.done), 1);
    chk("t4_error_cleared", 32'(bif.error), 0);
    chk("t4_cpu_hold", 32'(bif.cpu_hold), 0);
    do_start(16'd256);
    chk("t4_cap_busy", 32'(bif.busy), 1);
    chk("t4_cap_error", 32'(bif.error), 0);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Start mid-load ignored
    expect_wr(32'h0, 32'hAABB_CCDD);
    expect_wr(32'h4, 32'h1122_3344);
    do_start(16'd2);
    send_byte(8'hDD, 1'b0);
    send_byte(8'hCC, 1'b0);
    do_start(16'd1);
    chk("t5_still_busy", 32'(bif.busy), 1);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hAA, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_not_done_early", 32'(bif.done), 0);
    send_word(32'h1122_3344, 1'b0);
    wait_end();
    chk("t5_done", 32'(bif.done), 1);
    chk("t5_q_empty", 32'(exp_q.size()), 0);

    // Reset mid-load after 5 bytes of a 3-word load
    expect_wr(32'h0, 32'h0403_0201);
    do_start(16'd3);
    for (int k = 1; k <= 5; k++) send_byte(8'(k), 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("t6_no_write_after_rst", 32'(bif.write_enable), 0);
    chk("t6_q_empty_mid", 32'(exp_q.size()), 0);
    expect_wr(32'h0, 32'h1234_5678);
    do_start(16'd1);
    send_word(32'h1234_5678, 1'b0);
    wait_end();
    chk("t6_done", 32'(bif.done), 1);
    chk("t6_q_empty", 32'(exp_q.size()), 0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
Writer-side front end for the instruction ROM. It receives a byte stream over a valid/ready handshake and packs it into little-endian 32-bit instruction words. It issues one-cycle word writes at ascending word-aligned addresses and holds the CPU until the image is fully loaded. It replaces the file-driven load path used in bring-up with a synthesizable loader.

Parameters:
ADDR_W, 32, width of the memory write address
MEM_DEPTH_WORDS, 256, capacity of the instruction memory in 32-bit words
BASE_ADDR, 0, byte address of the first written word (word aligned)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERR
load_len  input  16  number of 32-bit words to load; sampled on an accepted start
byte_valid  input  1  byte_data is valid this cycle
byte_data  input  8  next image byte, lowest-address byte first
byte_ready  output  1  loader can accept a byte this cycle
write_enable  output  1  one-cycle word write strobe to the instruction memory
wr_address  output  ADDR_W  byte address of the word being written
wr_data  output  32  instruction word being written
busy  output  1  a load is in progress
done  output  1  the last load completed successfully
error  output  1  the last start was rejected because load_len > MEM_DEPTH_WORDS
cpu_hold  output  1  CPU must not fetch while this is high

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous assertion, active low.
- Reset values: state=IDLE, byte_ready=0, write_enable=0, wr_address=0, wr_data=0, busy=0, done=0, error=0, cpu_hold=1, internal byte index=0, word index=0.
- States are IDLE, COLLECT, WRITE, DONE and ERR.
- IDLE:
  - start with load_len=0 -> DONE.
  - start with load_len > MEM_DEPTH_WORDS -> ERR.
  - Any other start -> COLLECT; clear the word index and byte index, and latch load_len.
- COLLECT:
  - byte_ready=1 and busy=1.
  - A byte transfers only when byte_valid && byte_ready.
  - Byte k (k=0..3) is stored in bits [8k+7:8k] of the assembly register. The byte index increments on each transfer.
  - On the 4th transfer, go to WRITE on the next edge.
  - Bytes are never dropped or duplicated. With no valid byte, the loader waits indefinitely.
- WRITE:
  - Lasts exactly one cycle. byte_ready=0, write_enable=1, wr_data=assembled word.
  - wr_address = BASE_ADDR + 4*word_index, truncated to ADDR_W bits.
  - Next edge: word_index increments and byte_index clears. If the new word_index equals load_len, go to DONE; otherwise return to COLLECT.
- Latency: a write appears the cycle after the 4th byte handshake. Throughput is at most one word per 5 cycles.
- DONE: done=1, busy=0, cpu_hold=0, byte_ready=0. done stays high until the next accepted start.
- ERR: error=1, busy=0, cpu_hold=1, byte_ready=0. error stays high until the next accepted start or reset.
- start in DONE or ERR behaves as in IDLE: done and error clear, and the same decision rules apply.
- start while busy (COLLECT or WRITE) is ignored; load_len is not re-sampled.
- wr_address and wr_data hold their last values when write_enable=0. Verification checks them only while write_enable=1.
- cpu_hold is 1 in every state except DONE.
- rst_n asserted mid-load aborts immediately. All outputs return to reset values. No further write occurs, and a partial word is discarded.

Test Plan:
- Reset, start with load_len=2, then bytes 0x13,0x00,0x00,0x00,0x93,0x00,0x10,0x00 back-to-back -> write 0x00000013 @0x0, write 0x00100093 @0x4, then done=1 and cpu_hold=0.
- Same load with byte_valid toggling every other cycle -> identical writes; byte_ready drops only in WRITE cycles; no extra writes.
- start with load_len=0 -> DONE next cycle, no write_enable pulse, cpu_hold=0.
- start with load_len=MEM_DEPTH_WORDS+1 (257) -> error=1, cpu_hold=1, no writes; a later start with load_len=1 clears error and loads normally.
- Second start issued mid-load after 2 bytes -> ignored; the original load_len completes with correct addresses.
- rst_n pulsed low after 5 bytes of a 3-word load -> outputs return to reset values immediately; a fresh load then writes from BASE_ADDR.
